// File: rtl/uart_rx_pkg.sv
// Shared definitions for the parameterised UART receiver: FSM states, legal
// oversampling ratios and the 2-of-3 vote. UART_RX_BREAK_DET_EN adds the BREAK state.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
`ifdef UART_RX_BREAK_DET_EN
    , ST_BREAK
`endif
  } rx_state_t;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  function automatic logic is_legal_prescale(input logic [5:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Link between the bit sampler (master) and the frame FSM (slave): the FSM
// enables counting and supplies the ratio, the sampler returns the voted bit.
interface uart_rx_param_if;
  logic       run;
  logic [5:0] prescale;
  logic       rx_sync;
  logic       sample_bit;
  logic       bit_done;

  modport master (input run, prescale, output rx_sync, sample_bit, bit_done);
  modport slave  (output run, prescale, input rx_sync, sample_bit, bit_done);
endinterface

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, per-bit edge counter and 3-point majority voter.
// bit_done marks edge prescale-1 of the current bit; sample_bit is valid then.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_in,
  uart_rx_param_if.master link
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [5:0]             edge_cnt;
  logic [2:0]             votes;
  logic [5:0]             half;

  assign half = {1'b0, link.prescale[5:1]};

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
  end

  // Counter rests at 0 whenever the FSM is not inside a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
      votes    <= '1;
    end else if (!link.run) begin
      edge_cnt <= '0;
    end else begin
      if (edge_cnt == link.prescale - 6'd1) edge_cnt <= '0;
      else                                  edge_cnt <= edge_cnt + 6'd1;
      if (edge_cnt == half - 6'd1) votes[0] <= link.rx_sync;
      if (edge_cnt == half)        votes[1] <= link.rx_sync;
      if (edge_cnt == half + 6'd1) votes[2] <= link.rx_sync;
    end
  end

  assign link.rx_sync    = sync_q[SYNC_STAGES-1];
  assign link.bit_done   = link.run && (edge_cnt == link.prescale - 6'd1);
  assign link.sample_bit = maj3(votes);

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with parity, 1/2 stop bits and overrun detection.
// Define UART_RX_BREAK_DET_EN to add break detection (brk_det port, BREAK state).
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STP2,
  input  logic                  out_ready,
  output logic                  Data_Valid,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  ovr_err,
`ifdef UART_RX_BREAK_DET_EN
  output logic                  brk_det,
`endif
  output rx_state_t             dbg_state
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  // Output handshake: Data_Valid=1 means P_DATA holds an undelivered frame; it is
  // consumed on any cycle with Data_Valid && out_ready. A new frame arriving while
  // one is held and not being consumed is dropped with ovr_err.
  uart_rx_param_if link ();

  rx_state_t             state, next_state;
  logic [5:0]            cfg_presc;
  logic                  cfg_par_en, cfg_par_typ, cfg_stp2;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_bad, stp_bad;
  logic                  start_go, frame_done, done_par_bad, done_stp_bad;
  logic                  frame_ok, load, ovr_now;
`ifdef UART_RX_BREAK_DET_EN
  logic                  all_zero, break_hit;
`endif

  uart_rx_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .clk   (CLK),
    .rst   (RST),
    .rx_in (RX_IN),
    .link  (link)
  );

`ifdef UART_RX_BREAK_DET_EN
  assign link.run = (state != ST_IDLE) && (state != ST_BREAK);
`else
  assign link.run = (state != ST_IDLE);
`endif
  assign link.prescale = cfg_presc;
  assign start_go      = (state == ST_IDLE) && !link.rx_sync;
  assign dbg_state     = state;

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state   = state;
    frame_done   = 1'b0;
    done_par_bad = 1'b0;
    done_stp_bad = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    break_hit    = 1'b0;
`endif
    case (state)
      ST_IDLE:   if (!link.rx_sync) next_state = ST_START;
      ST_START:  if (link.bit_done) next_state = link.sample_bit ? ST_IDLE : ST_DATA;
      ST_DATA:   if (link.bit_done && bit_idx == IDX_W'(DATA_WIDTH - 1))
                   next_state = cfg_par_en ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (link.bit_done) next_state = ST_STOP1;
      ST_STOP1: begin
        if (link.bit_done) begin
`ifdef UART_RX_BREAK_DET_EN
          if (all_zero && !link.sample_bit) begin
            next_state = ST_BREAK;
            break_hit  = 1'b1;
          end else
`endif
          if (cfg_stp2) begin
            next_state = ST_STOP2;
          end else begin
            next_state   = ST_IDLE;
            frame_done   = 1'b1;
            done_par_bad = par_bad;
            done_stp_bad = !link.sample_bit;
          end
        end
      end
      ST_STOP2: begin
        if (link.bit_done) begin
          next_state   = ST_IDLE;
          frame_done   = 1'b1;
          done_par_bad = par_bad;
          done_stp_bad = stp_bad | !link.sample_bit;
        end
      end
`ifdef UART_RX_BREAK_DET_EN
      ST_BREAK:  if (link.rx_sync) next_state = ST_IDLE;
`endif
      default:   next_state = ST_IDLE;
    endcase
  end

  assign frame_ok = frame_done && !done_par_bad && !done_stp_bad;
  assign load     = frame_ok && (!Data_Valid || out_ready);
  assign ovr_now  = frame_ok && Data_Valid && !out_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cfg_presc   <= PRESCALE_8;
      cfg_par_en  <= 1'b0;
      cfg_par_typ <= 1'b0;
      cfg_stp2    <= 1'b0;
      bit_idx     <= '0;
      shift_q     <= '0;
      par_bad     <= 1'b0;
      stp_bad     <= 1'b0;
      P_DATA      <= '0;
      Data_Valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      ovr_err     <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      all_zero    <= 1'b0;
      brk_det     <= 1'b0;
`endif
    end else begin
      par_err <= done_par_bad;
      stp_err <= done_stp_bad;
      ovr_err <= ovr_now;
`ifdef UART_RX_BREAK_DET_EN
      brk_det <= break_hit;
`endif
      // Frame settings are frozen at the start edge; an unsupported ratio falls back to 16.
      if (start_go) begin
        cfg_presc   <= is_legal_prescale(Prescale) ? Prescale : PRESCALE_16;
        cfg_par_en  <= PAR_EN;
        cfg_par_typ <= PAR_TYP;
        cfg_stp2    <= STP2;
        bit_idx     <= '0;
        par_bad     <= 1'b0;
        stp_bad     <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        all_zero    <= 1'b1;
`endif
      end
      if (link.bit_done) begin
        case (state)
          ST_DATA: begin
            shift_q <= {link.sample_bit, shift_q[DATA_WIDTH-1:1]};
            bit_idx <= bit_idx + IDX_W'(1);
`ifdef UART_RX_BREAK_DET_EN
            if (link.sample_bit) all_zero <= 1'b0;
`endif
          end
          ST_PARITY: begin
            par_bad <= (^shift_q) ^ link.sample_bit ^ cfg_par_typ;
`ifdef UART_RX_BREAK_DET_EN
            if (link.sample_bit) all_zero <= 1'b0;
`endif
          end
          ST_STOP1: if (!link.sample_bit) stp_bad <= 1'b1;
          default: ;
        endcase
      end
      if (load) begin
        P_DATA     <= shift_q;
        Data_Valid <= 1'b1;
      end else if (Data_Valid && out_ready) begin
        Data_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: drives serial frames bit by bit and checks
// deliveries, error pulses and FSM state. Honours UART_RX_BREAK_DET_EN.
module tb_uart_rx_param;
  import uart_rx_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STP2 = 1'b0;
  logic       out_ready = 1'b1;
  logic       Data_Valid;
  logic [7:0] P_DATA;
  logic       par_err, stp_err, ovr_err;
`ifdef UART_RX_BREAK_DET_EN
  logic       brk_det;
`endif
  rx_state_t  dbg_state;

  int checks = 0;
  int failures = 0;

  // clock / reset
  always #5 CLK = ~CLK;

  uart_rx_param #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STP2       (STP2),
    .out_ready  (out_ready),
    .Data_Valid (Data_Valid),
    .P_DATA     (P_DATA),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .ovr_err    (ovr_err),
`ifdef UART_RX_BREAK_DET_EN
    .brk_det    (brk_det),
`endif
    .dbg_state  (dbg_state)
  );

  // monitor: event counters and delivered-data queue, sampled on the falling edge
  int cyc = 0;
  int n_dv = 0, n_dv_cyc = 0, n_par = 0, n_stp = 0, n_ovr = 0, n_brk = 0, n_start = 0;
  int stp_cyc = 0;
  logic dv_prev = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (Data_Valid && !dv_prev) begin
      n_dv++;
      got_q.push_back(P_DATA);
    end
    if (Data_Valid) n_dv_cyc++;
    dv_prev = Data_Valid;
    if (par_err) n_par++;
    if (stp_err) begin
      n_stp++;
      stp_cyc = cyc;
    end
    if (ovr_err) n_ovr++;
`ifdef UART_RX_BREAK_DET_EN
    if (brk_det) n_brk++;
`endif
    if (dbg_state == ST_START) n_start++;
  end

  // driver tasks
  task automatic send_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input logic par_en,
                            input logic par_bit, input logic stp2, input logic stop1,
                            input logic stop2);
    Prescale = 6'(p);
    PAR_EN   = par_en;
    STP2     = stp2;
    send_bit(1'b0, p);
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    if (par_en) send_bit(par_bit, p);
    send_bit(stop1, p);
    if (stp2) send_bit(stop2, p);
    RX_IN = 1'b1;
  endtask

  // scoreboard drain: compare every delivered byte against the expected queue
  task automatic drain_scoreboard(input string tag);
    logic [7:0] e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        failures++;
        $display("FAIL %s_data got=none exp=%02h", tag, e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL %s_data got=%02h exp=%02h", tag, g, e);
        end
      end
    end
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL %s_extra got=%0d extra deliveries exp=0", tag, got_q.size());
      got_q.delete();
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (Data_Valid !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b exp=0", Data_Valid); end
    checks++;
    if (P_DATA !== 8'h00) begin failures++; $display("FAIL reset_pdata got=%02h exp=00", P_DATA); end
    checks++;
    if ({par_err, stp_err, ovr_err} !== 3'b000) begin
      failures++; $display("FAIL reset_errs got=%b exp=000", {par_err, stp_err, ovr_err});
    end
`ifdef UART_RX_BREAK_DET_EN
    checks++;
    if (brk_det !== 1'b0) begin failures++; $display("FAIL reset_brk got=%b exp=0", brk_det); end
`endif
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    checks++;
    if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_basic_p8();
    int s_cyc, s_err;
    s_cyc = n_dv_cyc;
    s_err = n_par + n_stp + n_ovr;
    out_ready = 1'b1;
    PAR_TYP = 1'b0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (14) @(negedge CLK);
    checks++;
    if (n_dv_cyc - s_cyc != 1) begin
      failures++; $display("FAIL basic_dv_width got=%0d cycles exp=1", n_dv_cyc - s_cyc);
    end
    checks++;
    if (n_par + n_stp + n_ovr - s_err != 0) begin
      failures++; $display("FAIL basic_errs got=%0d pulses exp=0", n_par + n_stp + n_ovr - s_err);
    end
    drain_scoreboard("basic");
  endtask

  task automatic test_parity_ok();
    int s_err;
    s_err = n_par + n_stp + n_ovr;
    out_ready = 1'b1;
    PAR_TYP = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (22) @(negedge CLK);
    PAR_TYP = 1'b1;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 32, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (38) @(negedge CLK);
    checks++;
    if (n_par + n_stp + n_ovr - s_err != 0) begin
      failures++; $display("FAIL parity_ok_errs got=%0d pulses exp=0", n_par + n_stp + n_ovr - s_err);
    end
    drain_scoreboard("parity_ok");
    PAR_TYP = 1'b0;
  endtask

  task automatic test_parity_err();
    int s_par, s_dv, s_stp;
    s_par = n_par; s_dv = n_dv; s_stp = n_stp;
    PAR_TYP = 1'b0;
    send_frame(8'h03, 16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (22) @(negedge CLK);
    checks++;
    if (n_par - s_par != 1) begin failures++; $display("FAIL parity_err_pulse got=%0d exp=1", n_par - s_par); end
    checks++;
    if (n_dv - s_dv != 0) begin failures++; $display("FAIL parity_err_dv got=%0d exp=0", n_dv - s_dv); end
    checks++;
    if (n_stp - s_stp != 0) begin failures++; $display("FAIL parity_err_stp got=%0d exp=0", n_stp - s_stp); end
  endtask

  task automatic test_stop2_err();
    int s_stp, s_dv, c0;
    s_stp = n_stp; s_dv = n_dv;
    c0 = cyc;
    send_frame(8'h5A, 32, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (40) @(negedge CLK);
    STP2 = 1'b0;
    checks++;
    if (n_stp - s_stp != 1) begin failures++; $display("FAIL stop2_pulse got=%0d exp=1", n_stp - s_stp); end
    // pulse belongs to the end of the 11th bit time (STOP2), not the end of STOP1
    checks++;
    if (stp_cyc - c0 < 11 * 32 || stp_cyc - c0 > 11 * 32 + 5) begin
      failures++; $display("FAIL stop2_timing got=%0d exp=%0d..%0d", stp_cyc - c0, 11 * 32, 11 * 32 + 5);
    end
    checks++;
    if (n_dv - s_dv != 0) begin failures++; $display("FAIL stop2_dv got=%0d exp=0", n_dv - s_dv); end
  endtask

  task automatic test_glitch();
    int s_start, s_dv, s_err;
    s_start = n_start; s_dv = n_dv; s_err = n_par + n_stp + n_ovr;
    Prescale = 6'd16;
    PAR_EN = 1'b0;
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (40) @(negedge CLK);
    checks++;
    if (n_start - s_start == 0) begin failures++; $display("FAIL glitch_start got=0 START cycles exp=>0"); end
    checks++;
    if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL glitch_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    checks++;
    if (n_dv - s_dv + n_par + n_stp + n_ovr - s_err != 0) begin
      failures++; $display("FAIL glitch_output got=%0d events exp=0", n_dv - s_dv + n_par + n_stp + n_ovr - s_err);
    end
  endtask

  task automatic test_overrun();
    int s_ovr, s_dv;
    s_ovr = n_ovr; s_dv = n_dv;
    out_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (14) @(negedge CLK);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (14) @(negedge CLK);
    checks++;
    if (Data_Valid !== 1'b1) begin failures++; $display("FAIL ovr_dv_held got=%b exp=1", Data_Valid); end
    checks++;
    if (P_DATA !== 8'h11) begin failures++; $display("FAIL ovr_pdata got=%02h exp=11", P_DATA); end
    checks++;
    if (n_ovr - s_ovr != 1) begin failures++; $display("FAIL ovr_pulse got=%0d exp=1", n_ovr - s_ovr); end
    checks++;
    if (n_dv - s_dv != 1) begin failures++; $display("FAIL ovr_dv_rise got=%0d exp=1", n_dv - s_dv); end
    out_ready = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (Data_Valid !== 1'b0) begin failures++; $display("FAIL ovr_dv_fall got=%b exp=0", Data_Valid); end
    checks++;
    if (P_DATA !== 8'h11) begin failures++; $display("FAIL ovr_pdata_after got=%02h exp=11", P_DATA); end
    drain_scoreboard("ovr");
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec [3];
    vec[0] = 8'hFF; vec[1] = 8'h00; vec[2] = 8'h81;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(vec[i]);
      send_frame(vec[i], 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    repeat (14) @(negedge CLK);
    drain_scoreboard("b2b");
  endtask

  task automatic test_cfg_latch();
    logic [7:0] d;
    int s_err;
    d = 8'h96;
    s_err = n_par + n_stp + n_ovr;
    Prescale = 6'd8; PAR_EN = 1'b0; STP2 = 1'b0;
    exp_q.push_back(d);
    send_bit(1'b0, 8);
    Prescale = 6'd16; PAR_EN = 1'b1; STP2 = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(d[i], 8);
    send_bit(1'b1, 8);
    repeat (30) @(negedge CLK);
    checks++;
    if (n_par + n_stp + n_ovr - s_err != 0) begin
      failures++; $display("FAIL cfg_latch_errs got=%0d pulses exp=0", n_par + n_stp + n_ovr - s_err);
    end
    drain_scoreboard("cfg_latch");
    Prescale = 6'd8; PAR_EN = 1'b0; STP2 = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int s_dv, s_err;
    s_dv = n_dv; s_err = n_par + n_stp + n_ovr;
    Prescale = 6'd8;
    send_bit(1'b0, 8);
    send_bit(1'b0, 8);
    send_bit(1'b0, 8);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL midrst_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    RX_IN = 1'b1;
    RST = 1'b0;
    repeat (100) @(negedge CLK);
    checks++;
    if (n_dv - s_dv + n_par + n_stp + n_ovr - s_err != 0) begin
      failures++; $display("FAIL midrst_output got=%0d events exp=0", n_dv - s_dv + n_par + n_stp + n_ovr - s_err);
    end
  endtask

  task automatic test_break();
    int s_stp, s_dv, s_brk;
    s_stp = n_stp; s_dv = n_dv; s_brk = n_brk;
    out_ready = 1'b1;
    Prescale = 6'd8; PAR_EN = 1'b0; STP2 = 1'b0;
    RX_IN = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    repeat (11 * 8) @(negedge CLK);
    checks++;
    if (dbg_state !== ST_BREAK) begin failures++; $display("FAIL brk_state got=%0d exp=%0d", dbg_state, ST_BREAK); end
    repeat (8) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (16) @(negedge CLK);
    checks++;
    if (n_brk - s_brk != 1) begin failures++; $display("FAIL brk_pulse got=%0d exp=1", n_brk - s_brk); end
    checks++;
    if (n_stp - s_stp != 0) begin failures++; $display("FAIL brk_stp got=%0d exp=0", n_stp - s_stp); end
`else
    repeat (10 * 8) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (16) @(negedge CLK);
    checks++;
    if (n_stp - s_stp != 1) begin failures++; $display("FAIL brk_as_stp got=%0d exp=1", n_stp - s_stp); end
`endif
    checks++;
    if (n_dv - s_dv != 0) begin failures++; $display("FAIL brk_dv got=%0d exp=0", n_dv - s_dv); end
    checks++;
    if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL brk_idle got=%0d exp=%0d", dbg_state, ST_IDLE); end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (14) @(negedge CLK);
    drain_scoreboard("brk_next");
  endtask

  initial begin
    test_reset();
    test_basic_p8();
    test_parity_ok();
    test_parity_err();
    test_stop2_err();
    test_glitch();
    test_overrun();
    test_back_to_back();
    test_cfg_latch();
    test_reset_midframe();
    test_break();
    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, RX_IN synchroniser depth, legal range 2..3.
REQ-003 SHALL have port CLK  input  1  oversampling clock; the only clock.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port RX_IN  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-007 SHALL have port PAR_EN  input  1  parity bit present.
REQ-008 SHALL have port PAR_TYP  input  1  parity type: 0 even, 1 odd.
REQ-009 SHALL have port STP2  input  1  two stop bits when 1.
REQ-010 SHALL have port out_ready  input  1  consumer accepts P_DATA.
REQ-011 SHALL have port Data_Valid  output  1  P_DATA holds an undelivered frame.
REQ-012 SHALL have port P_DATA  output  DATA_WIDTH  received data, LSB first on the line.
REQ-013 SHALL have ports par_err, stp_err, ovr_err  output  1 each  one-cycle error pulses.
REQ-014 SHALL have port brk_det  output  1  one-cycle break pulse; present only under UART_RX_BREAK_DET_EN.

Function
REQ-015 SHALL pass RX_IN through SYNC_STAGES flops; all decisions use the synchronised value.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP1, STOP2 (and BREAK, see REQ-031).
REQ-017 SHALL leave IDLE for START in the cycle after the synchronised line is sampled low, clearing the edge counter.
REQ-018 SHALL latch Prescale, PAR_EN, PAR_TYP and STP2 on the IDLE->START transition; mid-frame changes are ignored.
REQ-019 SHALL count edges 0..Prescale-1 per bit and advance a bit only at edge Prescale-1.
REQ-020 SHALL sample at edges Prescale/2-1, Prescale/2 and Prescale/2+1 and take the 2-of-3 majority as the bit value.
REQ-021 SHALL return from START to IDLE without any output if the start bit majority is 1 (glitch).
REQ-022 SHALL shift DATA_WIDTH bits LSB first in DATA, then go to PARITY if PAR_EN, else to STOP1.
REQ-023 SHALL flag parity error when data XOR parity bit XOR PAR_TYP is 1.
REQ-024 SHALL flag stop error when any stop bit majority is 0; STOP2 is entered only when STP2 is latched.
REQ-025 SHALL complete the frame at edge Prescale-1 of the last stop bit and enter IDLE in the following cycle.
REQ-026 SHALL, at completion with no error, load P_DATA and set Data_Valid if Data_Valid is 0 or out_ready is 1 in that cycle.
REQ-027 SHALL, at completion with no error while Data_Valid=1 and out_ready=0, pulse ovr_err, drop the new frame and keep P_DATA unchanged.
REQ-028 SHALL clear Data_Valid on a cycle with Data_Valid=1 and out_ready=1 and no simultaneous load.
REQ-029 SHALL, at completion with an error, pulse par_err and/or stp_err and deliver no data.

Reset
REQ-030 SHALL, while RST=1 at a CLK edge, force IDLE, clear the counters, set the synchroniser flops to 1, and drive P_DATA=0, Data_Valid=0, par_err=0, stp_err=0, ovr_err=0, brk_det=0; a frame in progress is discarded.

Configuration
REQ-031 SHALL, with UART_RX_BREAK_DET_EN defined, treat a frame whose data bits, parity bit (if enabled) and first stop bit are all 0 as a break: pulse brk_det instead of stp_err, then hold in BREAK until the synchronised line is 1, then enter IDLE.
REQ-032 SHALL, without UART_RX_BREAK_DET_EN, omit brk_det and BREAK and report such a frame as stp_err with return to IDLE.

Structure
REQ-033 SHALL place the state enumeration and the legal Prescale constants (8, 16, 32) in the shared package uart_rx_pkg.
REQ-034 SHALL implement the synchroniser, edge counter and majority voter as the sub-module uart_rx_sampler, which outputs the sampled bit and a bit-done strobe.

Verification
REQ-035 SHALL check: Prescale=8, no parity, 1 stop bit, frame 0xA5, out_ready=1 -> Data_Valid pulses one cycle with P_DATA=0xA5 and no error flags.
REQ-036 SHALL check: Prescale=16, PAR_EN=1, PAR_TYP=0, data 0x03 sent with parity bit 1 -> par_err pulses once and Data_Valid stays 0.
REQ-037 SHALL check: Prescale=32, STP2=1, second stop bit driven 0 -> stp_err pulses at the end of STOP2.
REQ-038 SHALL check: start bit low for 3 cycles at Prescale=16 -> FSM returns to IDLE and no output is produced.
REQ-039 SHALL check: frames 0x11 then 0x22 with out_ready=0 -> P_DATA=0x11 is held, ovr_err pulses once, and after out_ready=1 Data_Valid falls.
REQ-040 SHALL check: with UART_RX_BREAK_DET_EN defined, the line held low for 12 bit times -> brk_det pulses once, and the next valid frame 0x5A is received after the line returns high.
